// File: rtl/lcv_dot_seq.sv
// Dot-product sequencer for an external 1-cycle registered signed MAC.
// Streams operand pairs into the MAC, recirculates its output, and returns one sum per vector.
module lcv_dot_seq #(
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [15:0]      in_a_i,
  input  logic [15:0]      in_b_i,
  input  logic             in_last_i,
  input  logic [32:0]      bias_i,
  output logic [15:0]      mac_a_o,
  output logic [15:0]      mac_b_o,
  output logic [32:0]      mac_c_o,
  output logic [32:0]      mac_d_o,
  output logic [32:0]      mac_e_o,
  input  logic [32:0]      mac_outp_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [32:0]      out_sum_o,
  output logic [CNT_W-1:0] out_count_o,
  output logic             out_err_o
);

  localparam int unsigned OP_W  = 16;
  localparam int unsigned SUM_W = 33;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               noend_q, noend_d;
  logic               out_valid_q, out_valid_d;
  logic [SUM_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_err_q, out_err_d;
  logic               acc;
  logic               at_limit;

  assign in_ready_o = (state_q == IDLE) || (state_q == RUN);
  assign acc        = in_valid_i && in_ready_o;
  assign at_limit   = (cnt_q == CNT_W'(MAX_LEN - 1));

  // Unqualified operands are forced to zero so bubbles leave the accumulator untouched.
  assign mac_a_o = acc ? in_a_i : OP_W'(0);
  assign mac_b_o = acc ? in_b_i : OP_W'(0);
  assign mac_d_o = SUM_W'(0);
  assign mac_e_o = SUM_W'(0);

  always_comb begin
    mac_c_o = SUM_W'(0);
    case (state_q)
      IDLE:        mac_c_o = bias_i;
      RUN, DRAIN:  mac_c_o = mac_outp_i;
      default:     mac_c_o = SUM_W'(0);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    noend_d     = noend_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_err_d   = out_err_q;

    if (acc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (acc) begin
          state_d = in_last_i ? DRAIN : RUN;
          noend_d = 1'b0;
        end
      end
      RUN: begin
        if (acc && (in_last_i || at_limit)) begin
          state_d = DRAIN;
          noend_d = !in_last_i;
        end
      end
      DRAIN: begin
        // MAC output now holds the sum including the terminating beat.
        out_sum_d   = mac_outp_i;
        out_count_d = cnt_q;
        out_err_d   = noend_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          cnt_d       = CNT_W'(0);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_W'(0);
      noend_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= SUM_W'(0);
      out_count_q <= CNT_W'(0);
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      noend_q     <= noend_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_sum_o   = out_sum_q;
  assign out_count_o = out_count_q;
  assign out_err_o   = out_err_q;

endmodule

// File: tb/tb_lcv_dot_seq.sv
// Bench for lcv_dot_seq: behavioural MAC in the loop, expected results queued per vector.
module tb_lcv_dot_seq;

  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

  typedef struct packed {
    logic [32:0]      sum;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } res_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_a = '0;
  logic [15:0]      in_b = '0;
  logic             in_last = 1'b0;
  logic [32:0]      bias = '0;
  logic [15:0]      mac_a, mac_b;
  logic [32:0]      mac_c, mac_d, mac_e;
  logic [32:0]      mac_outp = '0;
  logic signed [32:0] prod;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [32:0]      out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_err;

  int n_chk  = 0;
  int n_fail = 0;
  res_t exp_q[$];
  res_t obs_q[$];

  lcv_dot_seq #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b), .in_last_i(in_last), .bias_i(bias),
    .mac_a_o(mac_a), .mac_b_o(mac_b), .mac_c_o(mac_c), .mac_d_o(mac_d), .mac_e_o(mac_e),
    .mac_outp_i(mac_outp),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_sum_o(out_sum), .out_count_o(out_count), .out_err_o(out_err)
  );

  always #5 clk = ~clk;

  // Registered MAC the sequencer is built to drive.
  assign prod = 33'($signed(mac_a)) * 33'($signed(mac_b));
  always @(posedge clk) mac_outp <= prod + mac_c + mac_d + mac_e;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) obs_q.push_back({out_sum, out_count, out_err});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    while (!in_ready && n < 100) begin tick(); n++; end
    n_chk++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL beat_accept: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic get_obs(output res_t o, output res_t e, output bit ok);
    int n = 0;
    while (obs_q.size() == 0 && n < 100) begin tick(); n++; end
    ok = (obs_q.size() != 0) && (exp_q.size() != 0);
    o = '0; e = '0;
    if (ok) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b required 0", out_valid); end
    n_chk++; if (out_sum !== 33'd0) begin n_fail++; $display("FAIL reset_sum: got %0d required 0", out_sum); end
    n_chk++; if (out_count !== CNT_W'(0)) begin n_fail++; $display("FAIL reset_count: got %0d required 0", out_count); end
    n_chk++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b required 0", out_err); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b required 1", in_ready); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    res_t o, e; bit ok;
    bias = 33'd10; out_ready = 1'b1;
    exp_q.push_back('{33'sd5, CNT_W'(3), 1'b0});
    send_beat(16'sd3, 16'sd4, 1'b0);
    send_beat(-16'sd2, 16'sd5, 1'b0);
    send_beat(16'sd7, -16'sd1, 1'b1);
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency_t1: out_valid=%0b required 0", out_valid); end
    n_chk++; if (mac_d !== 33'd0 || mac_e !== 33'd0) begin n_fail++; $display("FAIL basic_mac_de: d=%0h e=%0h required 0", mac_d, mac_e); end
    tick();
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency_t2: out_valid=%0b required 1", out_valid); end
    tick();
    get_obs(o, e, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL basic_result: got no result, required one"); end
    n_chk++; if (o.sum !== e.sum) begin n_fail++; $display("FAIL basic_sum: got %0d required %0d", $signed(o.sum), $signed(e.sum)); end
    n_chk++; if (o.cnt !== e.cnt) begin n_fail++; $display("FAIL basic_count: got %0d required %0d", o.cnt, e.cnt); end
    n_chk++; if (o.err !== e.err) begin n_fail++; $display("FAIL basic_err: got %0b required %0b", o.err, e.err); end
  endtask

  task automatic test_bubble();
    res_t o, e; bit ok;
    bias = 33'd10;
    exp_q.push_back('{33'sd5, CNT_W'(3), 1'b0});
    send_beat(16'sd3, 16'sd4, 1'b0);
    in_a = 16'h7fff; in_b = 16'h7fff; in_last = 1'b1;
    @(negedge clk);
    n_chk++; if (mac_a !== 16'd0 || mac_b !== 16'd0) begin n_fail++; $display("FAIL bubble_mac_ab: a=%0h b=%0h required 0", mac_a, mac_b); end
    tick();
    tick();
    send_beat(-16'sd2, 16'sd5, 1'b0);
    send_beat(16'sd7, -16'sd1, 1'b1);
    get_obs(o, e, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL bubble_result: got no result, required one"); end
    n_chk++; if (o.sum !== e.sum) begin n_fail++; $display("FAIL bubble_sum: got %0d required %0d", $signed(o.sum), $signed(e.sum)); end
    n_chk++; if (o.cnt !== e.cnt) begin n_fail++; $display("FAIL bubble_count: got %0d required %0d", o.cnt, e.cnt); end
  endtask

  task automatic test_extremes();
    res_t o, e; bit ok;
    bias = 33'd0;
    exp_q.push_back('{33'd1073741824, CNT_W'(1), 1'b0});
    send_beat(16'h8000, 16'h8000, 1'b1);
    get_obs(o, e, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL single_result: got no result, required one"); end
    n_chk++; if (o.sum !== e.sum) begin n_fail++; $display("FAIL single_sum: got %0d required %0d", $signed(o.sum), $signed(e.sum)); end
    n_chk++; if (o.cnt !== e.cnt) begin n_fail++; $display("FAIL single_count: got %0d required %0d", o.cnt, e.cnt); end
    // Largest positive bias plus one wraps to the most negative 33-bit value.
    bias = 33'h0_ffff_ffff;
    exp_q.push_back('{33'h1_0000_0000, CNT_W'(1), 1'b0});
    send_beat(16'sd1, 16'sd1, 1'b1);
    get_obs(o, e, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL wrap_result: got no result, required one"); end
    n_chk++; if (o.sum !== e.sum) begin n_fail++; $display("FAIL wrap_sum: got %0h required %0h", o.sum, e.sum); end
  endtask

  task automatic test_forced();
    res_t o, e; bit ok;
    bias = 33'd0;
    exp_q.push_back('{33'sd4, CNT_W'(4), 1'b1});
    exp_q.push_back('{33'sd5, CNT_W'(2), 1'b0});
    for (int i = 0; i < 5; i++) send_beat(16'sd1, 16'sd1, 1'b0);
    send_beat(16'sd2, 16'sd2, 1'b1);
    for (int k = 0; k < 2; k++) begin
      get_obs(o, e, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL forced_result%0d: got no result, required one", k); end
      n_chk++; if (o.sum !== e.sum) begin n_fail++; $display("FAIL forced_sum%0d: got %0d required %0d", k, $signed(o.sum), $signed(e.sum)); end
      n_chk++; if (o.cnt !== e.cnt) begin n_fail++; $display("FAIL forced_count%0d: got %0d required %0d", k, o.cnt, e.cnt); end
      n_chk++; if (o.err !== e.err) begin n_fail++; $display("FAIL forced_err%0d: got %0b required %0b", k, o.err, e.err); end
    end
  endtask

  task automatic test_back_to_back();
    res_t o, e; bit ok;
    bias = 33'd1; out_ready = 1'b0;
    exp_q.push_back('{-33'sd4, CNT_W'(2), 1'b0});
    exp_q.push_back('{33'sd26, CNT_W'(1), 1'b0});
    send_beat(16'sd2, 16'sd2, 1'b0);
    send_beat(16'sd3, -16'sd3, 1'b1);
    tick();
    // Next vector's first beat waits while the result is stalled.
    in_valid = 1'b1; in_a = 16'sd5; in_b = 16'sd5; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready%0d: got %0b required 0", i, in_ready); end
      n_chk++; if (out_valid !== 1'b1 || out_sum !== -33'sd4 || out_count !== CNT_W'(2) || out_err !== 1'b0)
        begin n_fail++; $display("FAIL stall_hold%0d: valid=%0b sum=%0d cnt=%0d err=%0b required 1/-4/2/0",
                                 i, out_valid, $signed(out_sum), out_count, out_err); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL post_hs: ready=%0b valid=%0b required 1/0", in_ready, out_valid); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL next_accept: in_ready=%0b required 0 (beat taken)", in_ready); end
    tick();
    for (int k = 0; k < 2; k++) begin
      get_obs(o, e, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL b2b_result%0d: got no result, required one", k); end
      n_chk++; if (o.sum !== e.sum) begin n_fail++; $display("FAIL b2b_sum%0d: got %0d required %0d", k, $signed(o.sum), $signed(e.sum)); end
      n_chk++; if (o.cnt !== e.cnt) begin n_fail++; $display("FAIL b2b_count%0d: got %0d required %0d", k, o.cnt, e.cnt); end
    end
  endtask

  task automatic test_rst_mid();
    res_t o, e; bit ok;
    bias = 33'd100;
    send_beat(16'sd9, 16'sd9, 1'b0);
    send_beat(16'sd9, 16'sd9, 1'b0);
    rst = 1'b1; bias = 33'd7;
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state: ready=%0b valid=%0b required 1/0", in_ready, out_valid); end
    n_chk++; if (mac_c !== 33'd7) begin n_fail++; $display("FAIL rst_mid_macc: got %0d required 7", mac_c); end
    tick();
    rst = 1'b0; bias = 33'd0;
    exp_q.push_back('{33'sd6, CNT_W'(1), 1'b0});
    send_beat(16'sd2, 16'sd3, 1'b1);
    get_obs(o, e, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rst_result: got no result, required one"); end
    n_chk++; if (o.sum !== e.sum) begin n_fail++; $display("FAIL rst_sum: got %0d required %0d", $signed(o.sum), $signed(e.sum)); end
    n_chk++; if (o.cnt !== e.cnt) begin n_fail++; $display("FAIL rst_count: got %0d required %0d", o.cnt, e.cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubble();
    test_extremes();
    test_forced();
    test_back_to_back();
    test_rst_mid();
    repeat (3) tick();
    n_chk++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: obs=%0d exp=%0d left, required 0/0", obs_q.size(), exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
